// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry adder.
// Holds the default width and the result bundle layout.
package rca_pkg;

   localparam int RCA_DEFAULT_WIDTH = 16;
   localparam int RCA_MAX_WIDTH     = 64;

   typedef struct packed {
      logic [RCA_MAX_WIDTH-1:0] sum;
      logic                     c_out;
   } rca_result_t;

endpackage

// File: rtl/rca_full_adder.sv
// One-bit full adder cell of the ripple-carry chain.
// Purely combinational; instantiated once per sum bit.
module rca_full_adder
   import rca_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_adder.sv
// Registered ripple-carry adder, one result per cycle, 1-cycle latency.
// Optional signed overflow output ovf is enabled by RCA_OVERFLOW_EN.
module rca_adder
   import rca_pkg::*;
#(
   parameter int BIT_WIDTH = RCA_DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BIT_WIDTH-1:0] add_1,
   input  logic [BIT_WIDTH-1:0] add_2,
   input  logic                 c_in,
   input  logic                 in_valid,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 c_out,
   output logic                 out_valid
`ifdef RCA_OVERFLOW_EN
   ,
   output logic                 ovf
`endif
);

   logic [BIT_WIDTH:0]   carry;
   logic [BIT_WIDTH-1:0] sum_c;

   assign carry[0] = c_in;

   for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_chain
      rca_full_adder u_fa (
         .a  (add_1[i]),
         .b  (add_2[i]),
         .ci (carry[i]),
         .s  (sum_c[i]),
         .co (carry[i+1])
      );
   end

   // Capture chain result on valid; hold data and drop valid otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum       <= '0;
         c_out     <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         sum       <= sum_c;
         c_out     <= carry[BIT_WIDTH];
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

`ifdef RCA_OVERFLOW_EN
   // Signed overflow: carry into the MSB disagrees with carry out of it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= carry[BIT_WIDTH-1] ^ carry[BIT_WIDTH];
      end
   end
`endif

endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder at BIT_WIDTH=16 and BIT_WIDTH=1.
// Build with RCA_OVERFLOW_EN defined to also check ovf.
module tb_rca_adder;
   import rca_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a16, b16, s16;
   logic        ci16, v16, co16, ov16;
   logic        a1, b1, s1, ci1, v1, co1, ov1;
`ifdef RCA_OVERFLOW_EN
   logic        ovf16, ovf1;
`endif

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   rca_adder #(.BIT_WIDTH(16)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .add_1     (a16),
      .add_2     (b16),
      .c_in      (ci16),
      .in_valid  (v16),
      .sum       (s16),
      .c_out     (co16),
      .out_valid (ov16)
`ifdef RCA_OVERFLOW_EN
      ,
      .ovf       (ovf16)
`endif
   );

   rca_adder #(.BIT_WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .add_1     (a1),
      .add_2     (b1),
      .c_in      (ci1),
      .in_valid  (v1),
      .sum       (s1),
      .c_out     (co1),
      .out_valid (ov1)
`ifdef RCA_OVERFLOW_EN
      ,
      .ovf       (ovf1)
`endif
   );

   function automatic rca_result_t golden(int w, logic [15:0] a,
                                          logic [15:0] b, logic ci);
      rca_result_t r;
      logic [63:0] full;
      logic [63:0] mask;
      mask    = (64'd1 << w) - 64'd1;
      full    = (64'(a) & mask) + (64'(b) & mask) + 64'(ci);
      r.sum   = full & mask;
      r.c_out = full[w];
      return r;
   endfunction

   task automatic drive16(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic v);
      a16 = a; b16 = b; ci16 = ci; v16 = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive16(16'hABCD, 16'h1234, 1'b1, 1'b1);
      a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; v1 = 1'b1;
      drive16(16'hABCD, 16'h1234, 1'b1, 1'b1);
      total++;
      if (s16 !== 16'd0 || co16 !== 1'b0 || ov16 !== 1'b0)
         $display("FAIL reset16: sum=%0d c=%b v=%b want 0 0 0",
                  s16, co16, ov16);
      else pass_cnt++;
      total++;
      if (s1 !== 1'b0 || co1 !== 1'b0 || ov1 !== 1'b0)
         $display("FAIL reset1: sum=%b c=%b v=%b want 0 0 0",
                  s1, co1, ov1);
      else pass_cnt++;
`ifdef RCA_OVERFLOW_EN
      total++;
      if (ovf16 !== 1'b0 || ovf1 !== 1'b0)
         $display("FAIL reset_ovf: %b %b want 0 0", ovf16, ovf1);
      else pass_cnt++;
`endif
      v1 = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      drive16(16'd12, 16'd15, 1'b0, 1'b1);
      total++;
      if (s16 !== 16'd27 || co16 !== 1'b0 || ov16 !== 1'b1)
         $display("FAIL basic: sum=%0d c=%b v=%b want 27 0 1",
                  s16, co16, ov16);
      else pass_cnt++;
   endtask

   task automatic test_carry_in();
      drive16(16'd12, 16'd15, 1'b1, 1'b1);
      total++;
      if (s16 !== 16'd28 || co16 !== 1'b0 || ov16 !== 1'b1)
         $display("FAIL carry_in: sum=%0d c=%b v=%b want 28 0 1",
                  s16, co16, ov16);
      else pass_cnt++;
   endtask

   task automatic test_near_overflow();
      drive16(16'd65534, 16'd1, 1'b0, 1'b1);
      total++;
      if (s16 !== 16'd65535 || co16 !== 1'b0)
         $display("FAIL near_ovf: sum=%0d c=%b want 65535 0", s16, co16);
      else pass_cnt++;
      drive16(16'd65534, 16'd1, 1'b1, 1'b1);
      total++;
      if (s16 !== 16'd0 || co16 !== 1'b1)
         $display("FAIL wrap: sum=%0d c=%b want 0 1", s16, co16);
      else pass_cnt++;
`ifdef RCA_OVERFLOW_EN
      total++;
      if (ovf16 !== 1'b0)
         $display("FAIL wrap_ovf: ovf=%b want 0", ovf16);
      else pass_cnt++;
      drive16(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      total++;
      if (ovf16 !== 1'b1 || s16 !== 16'h8000)
         $display("FAIL pos_ovf: ovf=%b sum=%h want 1 8000", ovf16, s16);
      else pass_cnt++;
`endif
   endtask

   task automatic test_hold();
      drive16(16'd100, 16'd200, 1'b0, 1'b1);
      drive16(16'd7, 16'd9, 1'b1, 1'b0);
      total++;
      if (s16 !== 16'd300 || co16 !== 1'b0 || ov16 !== 1'b0)
         $display("FAIL hold: sum=%0d c=%b v=%b want 300 0 0",
                  s16, co16, ov16);
      else pass_cnt++;
      drive16(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      drive16(16'h0001, 16'h0001, 1'b0, 1'b0);
      total++;
      if (s16 !== 16'd0 || co16 !== 1'b1 || ov16 !== 1'b0)
         $display("FAIL hold_carry: sum=%0d c=%b v=%b want 0 1 0",
                  s16, co16, ov16);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      drive16(16'd5, 16'd6, 1'b0, 1'b1);
      rst_n = 1'b0;
      drive16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      total++;
      if (s16 !== 16'd0 || co16 !== 1'b0 || ov16 !== 1'b0)
         $display("FAIL reset_mid: sum=%0d c=%b v=%b want 0 0 0",
                  s16, co16, ov16);
      else pass_cnt++;
      rst_n = 1'b1;
      drive16(16'd3, 16'd4, 1'b0, 1'b0);
      total++;
      if (s16 !== 16'd0 || ov16 !== 1'b0)
         $display("FAIL post_reset_idle: sum=%0d v=%b want 0 0", s16, ov16);
      else pass_cnt++;
      drive16(16'd3, 16'd4, 1'b0, 1'b1);
      total++;
      if (s16 !== 16'd7 || ov16 !== 1'b1)
         $display("FAIL first_valid: sum=%0d v=%b want 7 1", s16, ov16);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      drive16(16'h1234, 16'h4321, 1'b0, 1'b1);
      total++;
      if (s16 !== 16'h5555 || co16 !== 1'b0 || ov16 !== 1'b1)
         $display("FAIL b2b_0: sum=%h c=%b want 5555 0", s16, co16);
      else pass_cnt++;
      drive16(16'h8000, 16'h8000, 1'b1, 1'b1);
      total++;
      if (s16 !== 16'h0001 || co16 !== 1'b1 || ov16 !== 1'b1)
         $display("FAIL b2b_1: sum=%h c=%b want 0001 1", s16, co16);
      else pass_cnt++;
      drive16(16'h00FF, 16'h0F01, 1'b0, 1'b1);
      total++;
      if (s16 !== 16'h1000 || co16 !== 1'b0 || ov16 !== 1'b1)
         $display("FAIL b2b_2: sum=%h c=%b want 1000 0", s16, co16);
      else pass_cnt++;
   endtask

   task automatic test_width1();
      v16 = 1'b0;
      a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; v1 = 1'b1;
      @(posedge clk); #1;
      total++;
      if (s1 !== 1'b1 || co1 !== 1'b1 || ov1 !== 1'b1)
         $display("FAIL w1_111: sum=%b c=%b v=%b want 1 1 1", s1, co1, ov1);
      else pass_cnt++;
      a1 = 1'b0; b1 = 1'b0; ci1 = 1'b1;
      @(posedge clk); #1;
      total++;
      if (s1 !== 1'b1 || co1 !== 1'b0)
         $display("FAIL w1_001: sum=%b c=%b want 1 0", s1, co1);
      else pass_cnt++;
      a1 = 1'b1; b1 = 1'b0; ci1 = 1'b1;
      @(posedge clk); #1;
      total++;
      if (s1 !== 1'b0 || co1 !== 1'b1)
         $display("FAIL w1_101: sum=%b c=%b want 0 1", s1, co1);
      else pass_cnt++;
   endtask

   task automatic test_random();
      rca_result_t e16, e1;
      int bad = 0;
      for (int i = 0; i < 10000; i++) begin
         a16 = 16'($urandom); b16 = 16'($urandom);
         ci16 = 1'($urandom); v16 = 1'b1;
         a1 = 1'($urandom); b1 = 1'($urandom);
         ci1 = 1'($urandom); v1 = 1'b1;
         e16 = golden(16, a16, b16, ci16);
         e1  = golden(1, {15'd0, a1}, {15'd0, b1}, ci1);
         @(posedge clk); #1;
         total++;
         if (s16 !== e16.sum[15:0] || co16 !== e16.c_out) begin
            if (bad < 5)
               $display("FAIL rand16: got %b_%h want %b_%h",
                        co16, s16, e16.c_out, e16.sum[15:0]);
            bad++;
         end else pass_cnt++;
         total++;
         if (s1 !== e1.sum[0] || co1 !== e1.c_out) begin
            if (bad < 5)
               $display("FAIL rand1: got %b%b want %b%b",
                        co1, s1, e1.c_out, e1.sum[0]);
            bad++;
         end else pass_cnt++;
      end
      v16 = 1'b0; v1 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      a16 = '0; b16 = '0; ci16 = 1'b0; v16 = 1'b0;
      a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0; v1 = 1'b0;
      test_reset();
      test_basic();
      test_carry_in();
      test_near_overflow();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_width1();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/rca_adder.md
RCA_ADDER -- requirements
Module: rca_adder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter BIT_WIDTH, default 16, SHALL set the operand and sum width (legal range 1..64).
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst_n  input  1  synchronous active-low reset.
REQ-005 Port add_1  input  BIT_WIDTH  unsigned operand A.
REQ-006 Port add_2  input  BIT_WIDTH  unsigned operand B.
REQ-007 Port c_in  input  1  carry-in.
REQ-008 Port in_valid  input  1  operands valid this cycle.
REQ-009 Port sum  output  BIT_WIDTH  registered sum bits.
REQ-010 Port c_out  output  1  registered carry-out.
REQ-011 Port out_valid  output  1  sum/c_out valid.

Function
REQ-012 The datapath SHALL be a ripple-carry chain of BIT_WIDTH one-bit full adders: bit 0 takes c_in, each bit's carry feeds the next, and the top carry is c_out.
REQ-013 The chain SHALL compute {c_out, sum} = add_1 + add_2 + c_in exactly (BIT_WIDTH+1-bit result, no truncation of the carry).
REQ-014 Each full adder SHALL compute s = a ^ b ^ ci and co = (a & b) | (ci & (a ^ b)).
REQ-015 On a rising clk edge with rst_n=1 and in_valid=1, the result SHALL be registered into sum and c_out, and out_valid SHALL be set to 1.
REQ-016 Latency SHALL be exactly 1 cycle; throughput SHALL be one operation per cycle with no stalls or backpressure.
REQ-017 When in_valid=0 on an edge, sum and c_out SHALL hold their previous values and out_valid SHALL go to 0.
REQ-018 Wrap-around: an all-ones operand plus carry SHALL wrap sum modulo 2^BIT_WIDTH with c_out=1 (e.g. 65534+1+1 gives sum 0, c_out 1).
REQ-019 The carry-in SHALL be fully honoured at every width, including BIT_WIDTH=1.

Reset
REQ-020 When rst_n=0 at a rising clk edge, sum SHALL become 0, c_out 0, and out_valid 0, regardless of in_valid.
REQ-021 A reset asserted while in_valid=1 SHALL discard that operation; the first valid result SHALL appear one cycle after the first in_valid edge with rst_n=1.
REQ-022 The full-adder chain SHALL be purely combinational; only the output registers are reset.

Configuration
REQ-023 When macro RCA_OVERFLOW_EN is defined, an extra output port ovf (1 bit, registered, reset 0) SHALL report signed two's-complement overflow, computed as carry into MSB XOR c_out, updated under the same rules as sum.
REQ-024 When RCA_OVERFLOW_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-025 Shared package rca_pkg SHALL hold the default width constant RCA_DEFAULT_WIDTH=16 and the result struct type (sum, c_out).
REQ-026 The one-bit cell SHALL be a sub-module rca_full_adder (ports a, b, ci, s, co), instantiated BIT_WIDTH times through a generate loop.
REQ-027 The block SHALL NOT use a behavioural "+" for the main sum; the carry chain SHALL be explicit.

Verification
REQ-028 Reset: rst_n=0 for 2 cycles -> sum=0, c_out=0, out_valid=0.
REQ-029 Basic addition: 12+15, c_in=0, in_valid=1 -> next cycle sum=27, c_out=0, out_valid=1.
REQ-030 Carry-in: 12+15, c_in=1 -> sum=28, c_out=0.
REQ-031 Near-overflow: 65534+1, c_in=0 -> sum=65535, c_out=0; 65534+1, c_in=1 -> sum=0, c_out=1 (with RCA_OVERFLOW_EN, ovf=0).
REQ-032 Hold and reset mid-stream: in_valid=0 after a result -> sum holds and out_valid=0; rst_n=0 in the same cycle as in_valid=1 (0xFFFF+0xFFFF+1) -> outputs 0 next cycle.
REQ-033 Random regression: 10k random operands checked against a golden model for {c_out,sum} at BIT_WIDTH=16 and BIT_WIDTH=1.
